// File: rtl/sub_arbiter.sv
// sub_arbiter: round-robin front end for one shared, registered subtractor.
// Grants one requester at a time, launches its operands into the subtractor,
// waits out the subtractor latency and returns the difference with flags.

// Per-requester slice: raises this lane's accept strobe when it is the
// round-robin winner and masks its operands onto the shared operand bus.
module sub_arbiter_lane #(
    parameter int WIDTH = 16,
    parameter int IDW   = 2,
    parameter int IDX   = 0
) (
    input  logic             en,
    input  logic [IDW-1:0]   winner,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic [WIDTH-1:0] a_sel,
    output logic [WIDTH-1:0] b_sel
);
    // Lane is selected only when arbitration is open and it won the scan
    always_comb begin
        ready = en && (winner == IDW'(IDX));
        a_sel = ready ? a : '0;
        b_sel = ready ? b : '0;
    end
endmodule

module sub_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16,
    parameter int LAT   = 1,
    parameter int IDW   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]       sub_a,
    output logic [WIDTH-1:0]       sub_b,
    input  logic [WIDTH-1:0]       sub_diff,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [WIDTH-1:0]       rsp_diff,
    output logic                   rsp_borrow,
    output logic                   rsp_zero,
    output logic                   busy
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                        state, state_next;
    logic   [IDW-1:0]              ptr, ptr_next, winner;
    logic   [IDW:0]                off, best;
    logic                          any_valid, open, accept;
    logic   [2:0]                  cnt;
    logic                          borrow_q;
    logic   [N_REQ-1:0][WIDTH-1:0] lane_a, lane_b;
    logic   [WIDTH-1:0]            sel_a, sel_b;

    // Round-robin scan: pick the valid requester with the smallest distance
    // from ptr (distance wraps modulo N_REQ, so non-power-of-two counts work)
    always_comb begin
        winner    = '0;
        best      = (IDW+1)'(N_REQ);
        off       = '0;
        any_valid = |req_valid;
        for (int j = 0; j < N_REQ; j++) begin
            if (IDW'(j) >= ptr) off = (IDW+1)'(j) - {1'b0, ptr};
            else                off = (IDW+1)'(j + N_REQ) - {1'b0, ptr};
            if (req_valid[j] && off < best) begin
                best   = off;
                winner = IDW'(j);
            end
        end
        ptr_next = (winner == IDW'(N_REQ - 1)) ? '0 : winner + 1'b1;
        // No accept while reset is held, so nothing is granted and then dropped
        open     = (state == IDLE) && any_valid && !rst;
        accept   = open;
        busy     = (state != IDLE);
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_lane
        sub_arbiter_lane #(.WIDTH(WIDTH), .IDW(IDW), .IDX(g)) u_lane (
            .en     (open),
            .winner (winner),
            .a      (req_a[g*WIDTH +: WIDTH]),
            .b      (req_b[g*WIDTH +: WIDTH]),
            .ready  (req_ready[g]),
            .a_sel  (lane_a[g]),
            .b_sel  (lane_b[g])
        );
    end

    // OR-combine the masked lane operands; at most one lane is non-zero
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int j = 0; j < N_REQ; j++) begin
            sel_a = sel_a | lane_a[j];
            sel_b = sel_b | lane_b[j];
        end
    end

    // Next-state: grant -> wait out the subtractor -> hold response until taken
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = WAIT;
            WAIT:    if (cnt == 3'(LAT)) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Datapath: launch operands on accept, capture result after LAT+1 cycles.
    // Borrow is taken from the operands here rather than from sub_diff so it
    // stays correct regardless of how the shared unit reports overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            cnt        <= '0;
            borrow_q   <= 1'b0;
            sub_a      <= '0;
            sub_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_diff   <= '0;
            rsp_borrow <= 1'b0;
            rsp_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    sub_a    <= sel_a;
                    sub_b    <= sel_b;
                    rsp_id   <= winner;
                    borrow_q <= (sel_a < sel_b);
                    cnt      <= '0;
                    ptr      <= ptr_next;
                end
                WAIT: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'(LAT)) begin
                        rsp_diff   <= sub_diff;
                        rsp_borrow <= borrow_q;
                        rsp_zero   <= (sub_diff == '0);
                        rsp_valid  <= 1'b1;
                    end
                end
                RESP: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sub_arbiter.sv
// Bench for sub_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_sub_arbiter;
    localparam int N   = 4;
    localparam int W   = 16;
    localparam int LAT = 1;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a, req_b;
    logic [N-1:0]     req_ready;
    logic [W-1:0]     sub_a, sub_b, sub_diff;
    logic             rsp_valid, rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [W-1:0]     rsp_diff;
    logic             rsp_borrow, rsp_zero, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sub_arbiter #(.N_REQ(N), .WIDTH(W), .LAT(LAT), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .sub_a(sub_a), .sub_b(sub_b), .sub_diff(sub_diff),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_diff(rsp_diff), .rsp_borrow(rsp_borrow), .rsp_zero(rsp_zero), .busy(busy)
    );

    // Shared subtractor stand-in: LAT register stages of a - b
    logic [W-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= sub_a - sub_b;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign sub_diff = pipe[LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // One outstanding transaction at most; its response is due LAT+2 cycles
    // after the accept cycle and persists until a cycle with rsp_ready=1.
    bit           m_ok = 0;
    bit           m_busy;
    int           m_ptr, m_acc, m_id, cyc = 0;
    logic [W-1:0] m_a, m_b;

    always @(negedge clk) begin
        logic [N-1:0] e_ready;
        bit           e_rsp;
        int           w;
        e_ready = '0;
        w       = -1;
        if (!m_busy && |req_valid) begin
            for (int k = 0; k < N; k++)
                if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        end
        if (m_ok) begin
            if (!rst && w >= 0) e_ready[w] = 1'b1;
            e_rsp = m_busy && (cyc >= m_acc + LAT + 2);
            chk("m_req_ready", 32'(req_ready), 32'(e_ready));
            chk("m_busy",      32'(busy),      32'(m_busy));
            chk("m_rsp_valid", 32'(rsp_valid), 32'(e_rsp));
            chk("m_sub_a",     32'(sub_a),     32'(m_a));
            chk("m_sub_b",     32'(sub_b),     32'(m_b));
            if (e_rsp) begin
                chk("m_rsp_id",     32'(rsp_id),     32'(m_id));
                chk("m_rsp_diff",   32'(rsp_diff),   32'(W'(m_a - m_b)));
                chk("m_rsp_borrow", 32'(rsp_borrow), 32'(m_a < m_b));
                chk("m_rsp_zero",   32'(rsp_zero),   32'(m_a == m_b));
            end
        end
        // advance the model to reflect the coming rising edge
        if (rst) begin
            m_ok = 1; m_busy = 0; m_ptr = 0; m_a = '0; m_b = '0; m_id = 0;
        end else if (m_ok) begin
            if (w >= 0) begin
                m_busy = 1; m_acc = cyc; m_id = w;
                m_a = req_a[w*W +: W]; m_b = req_b[w*W +: W];
                m_ptr = (w + 1) % N;
            end else if (m_busy && cyc >= m_acc + LAT + 2 && rsp_ready) begin
                m_busy = 0;
            end
        end
        cyc++;
    end

    // ---------------- directed helpers ----------------
    // Called at posedge+1; returns at posedge+4 of the cycle rsp_valid is seen.
    task automatic wait_rsp(output int n);
        n = 0;
        #3;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #4;
            n++;
        end
        if (!rsp_valid) begin
            checks++; errors++;
            $display("FAIL wait_rsp: got timeout expected rsp_valid within 20 cycles");
        end
    endtask

    // Present a one-cycle request from the lanes in mask (called in IDLE at +1)
    task automatic issue(input logic [N-1:0] mask);
        req_valid = mask;
        #3;
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    logic [W-1:0] exp_diff [N];
    int n;

    initial begin
        exp_diff[0] = 16'h0D00; exp_diff[1] = 16'h1C01;
        exp_diff[2] = 16'h2B02; exp_diff[3] = 16'h3A03;
        rst = 1'b1; req_valid = '1; req_a = '0; req_b = '0; rsp_ready = 1'b1;

        // reset held with every requester asking
        @(posedge clk); @(posedge clk); #4;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_sub_a",     32'(sub_a),     32'h0);
        chk("rst_sub_b",     32'(sub_b),     32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = '0;

        // single request, latency pinned to LAT+2
        set_op(0, 16'h0005, 16'h0003);
        req_valid = 4'b0001;
        #3;
        chk("single_req_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(n);
        chk("single_latency", 32'(n + 1), 32'(LAT + 2));
        chk("single_id",      32'(rsp_id),     32'h0);
        chk("single_diff",    32'(rsp_diff),   32'h0002);
        chk("single_borrow",  32'(rsp_borrow), 32'h0);
        chk("single_zero",    32'(rsp_zero),   32'h0);
        @(posedge clk); #1;

        // negative result wraps, borrow set
        set_op(1, 16'h0003, 16'h0005);
        issue(4'b0010);
        wait_rsp(n);
        chk("neg_id",     32'(rsp_id),     32'h1);
        chk("neg_diff",   32'(rsp_diff),   32'hFFFE);
        chk("neg_borrow", 32'(rsp_borrow), 32'h1);
        @(posedge clk); #1;

        // zero result
        set_op(1, 16'h0000, 16'h0000);
        issue(4'b0010);
        wait_rsp(n);
        chk("zero_diff",   32'(rsp_diff),   32'h0000);
        chk("zero_zero",   32'(rsp_zero),   32'h1);
        chk("zero_borrow", 32'(rsp_borrow), 32'h0);
        @(posedge clk); #1;

        // contention from ptr=0: grants rotate 0,1,2,3,0,...
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < N; i++)
            set_op(i, W'(16'h1000 * (i + 1) + i), W'(16'h0100 * (i + 3)));
        req_valid = '1;
        for (int k = 0; k < 2 * N; k++) begin
            wait_rsp(n);
            chk("cont_id",   32'(rsp_id),   32'(k % N));
            chk("cont_diff", 32'(rsp_diff), 32'(exp_diff[k % N]));
            @(posedge clk); #1;
        end

        // backpressure: response held, no grants, then next grant to lane 1
        rsp_ready = 1'b0;
        wait_rsp(n);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #4;
            chk("bp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_id",    32'(rsp_id),    32'h0);
            chk("bp_diff",  32'(rsp_diff),  32'h0D00);
            chk("bp_ready", 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #4;
        chk("bp_after_valid", 32'(rsp_valid), 32'h0);
        chk("bp_next_grant",  32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid = '0;

        // reset during WAIT: operation dropped
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #3;
        chk("rstw_busy",  32'(busy),      32'h0);
        chk("rstw_valid", 32'(rsp_valid), 32'h0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #4;
            chk("rstw_stale", 32'(rsp_valid), 32'h0);
        end
        @(posedge clk); #1;

        // reset during RESP: response dropped, pointer back to 0
        rsp_ready = 1'b0;
        set_op(2, 16'h1234, 16'h0234);
        issue(4'b0100);
        wait_rsp(n);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = '1;
        #3;
        chk("rstr_valid", 32'(rsp_valid), 32'h0);
        chk("rstr_ptr0",  32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = '0; rsp_ready = 1'b1;

        // randomized traffic, occasional reset; the model checks every cycle
        for (int c = 0; c < 3000; c++) begin
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                logic [W-1:0] a;
                a = W'($urandom);
                set_op(i, a, ($urandom_range(0, 3) == 0) ? a : W'($urandom));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
